// File: rtl/pic8259_pkg.sv
// pic8259_pkg: shared definitions for the 8259A interrupt-acknowledge logic.
//   - control_state encodings (CTL_IDLE/CTL_ACK1/CTL_ACK2/CTL_ACK3)
//   - CALL opcode byte emitted in the first 8080-mode INTA pulse
//   - helpers that turn a priority-resolved request into an IR index / one-hot
package pic8259_pkg;

  typedef enum logic [2:0] {
    CTL_IDLE = 3'b000,
    CTL_ACK1 = 3'b001,
    CTL_ACK2 = 3'b010,
    CTL_ACK3 = 3'b011
  } ctl_state_t;

  localparam logic [7:0] CALL_OPCODE = 8'hCD;

  // Index of the lowest set request bit; an empty request is the spurious
  // case and reports level 7.
  function automatic logic [2:0] ir_encode(input logic [7:0] req);
    logic [2:0] idx;
    idx = 3'd7;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) begin
        idx = i[2:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Keeps only the lowest set bit (two's-complement trick); zero stays zero.
  function automatic logic [7:0] lowest_bit(input logic [7:0] req);
    return req & (~req + 8'd1);
  endfunction

endpackage

// File: rtl/inta_edge_detect.sv
// inta_edge_detect: edge detector for the (already synchronous) INTA pin.
// Ports:
//   clock, reset_n     system clock, asynchronous active-low reset
//   interrupt_ack_n    INTA pin
//   fall               registered one-cycle strobe: pin went low
//   rise               registered one-cycle strobe: pin went high
//   low                pin is low, aligned with the fall/rise strobes
module inta_edge_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic interrupt_ack_n,
  output logic fall,
  output logic rise,
  output logic low
);

  logic ack_d_r;
  logic fall_r;
  logic rise_r;

  // Delay the pin one clock and register the edge strobes so that they
  // line up with ack_d (which then serves as the "pin is low" qualifier).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ack_d_r <= 1'b1;
      fall_r  <= 1'b0;
      rise_r  <= 1'b0;
    end else begin
      ack_d_r <= interrupt_ack_n;
      fall_r  <= ack_d_r & ~interrupt_ack_n;
      rise_r  <= ~ack_d_r & interrupt_ack_n;
    end
  end

  assign fall = fall_r;
  assign rise = rise_r;
  assign low  = ~ack_d_r;

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// interrupt_ack_sequencer: steps the 8259A INTA acknowledge cycle, captures
// the acknowledged IR level and drives the vector / CALL bytes.
// Optional feature macro: INTA_TIMEOUT_EN (abort a stalled sequence after
// TIMEOUT_CYCLES clocks with INTA high; seq_abort tied low otherwise).
// Ports:
//   clock, reset_n            clock, asynchronous active-low reset
//   interrupt_ack_n           INTA pin (synchronous)
//   mode_8086, auto_eoi       ICW4 uPM / AEOI (captured on first INTA)
//   cascade_slave             device is a cascade slave
//   cascade_output_ack_2_3    this device owns the bus in ACK2/ACK3
//   interrupt_to_ack [7:0]    priority-resolved request (captured)
//   vector_base [4:0]         ICW2 T7..T3
//   call_base [15:0]          8080 CALL address base
//   call_interval_4           ICW1 ADI
//   control_state [2:0]       IDLE/ACK1/ACK2/ACK3
//   acknowledge_interrupt     captured one-hot level
//   latch_in_service, end_of_ack, auto_eoi_clear, seq_abort   1-clk pulses
//   data_out [7:0], data_out_enable                          bus drive
module interrupt_ack_sequencer
  import pic8259_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        interrupt_ack_n,
  input  logic        mode_8086,
  input  logic        auto_eoi,
  input  logic        cascade_slave,
  input  logic        cascade_output_ack_2_3,
  input  logic [7:0]  interrupt_to_ack,
  input  logic [4:0]  vector_base,
  input  logic [15:0] call_base,
  input  logic        call_interval_4,
  output logic [2:0]  control_state,
  output logic [7:0]  acknowledge_interrupt,
  output logic        latch_in_service,
  output logic        end_of_ack,
  output logic        auto_eoi_clear,
  output logic [7:0]  data_out,
  output logic        data_out_enable,
  output logic        seq_abort
);

  logic fall_s;
  logic rise_s;
  logic low_s;

  inta_edge_detect u_edge (
    .clock           (clock),
    .reset_n         (reset_n),
    .interrupt_ack_n (interrupt_ack_n),
    .fall            (fall_s),
    .rise            (rise_s),
    .low             (low_s)
  );

  ctl_state_t state_r, state_nxt_s;
  logic       mode_r, mode_nxt_s;
  logic       aeoi_r, aeoi_nxt_s;
  logic [2:0] ir_r, ir_nxt_s;
  logic [7:0] ack_r, ack_nxt_s;
  logic       latch_r, latch_nxt_s;
  logic       eoa_r, eoa_nxt_s;
  logic       aeoi_clr_r;
  logic       abort_r, abort_nxt_s;
  logic [7:0] dout_r, dout_nxt_s;
  logic       den_r, den_nxt_s;

`ifdef INTA_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic          timing_s;
`else
  // TIMEOUT_CYCLES only has an effect when the timeout counter is built.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  // Next-state, capture and pulse generation.
  always_comb begin
    state_nxt_s = state_r;
    mode_nxt_s  = mode_r;
    aeoi_nxt_s  = aeoi_r;
    ir_nxt_s    = ir_r;
    ack_nxt_s   = ack_r;
    latch_nxt_s = 1'b0;
    eoa_nxt_s   = 1'b0;
    abort_nxt_s = 1'b0;
    case (state_r)
      CTL_IDLE: begin
        if (fall_s) begin
          state_nxt_s = CTL_ACK1;
          mode_nxt_s  = mode_8086;
          aeoi_nxt_s  = auto_eoi;
          ir_nxt_s    = ir_encode(interrupt_to_ack);
          ack_nxt_s   = lowest_bit(interrupt_to_ack);
          latch_nxt_s = |interrupt_to_ack;
        end else begin
          state_nxt_s = CTL_IDLE;
        end
      end
      CTL_ACK1: begin
        if (fall_s) begin
          state_nxt_s = CTL_ACK2;
        end else begin
          state_nxt_s = CTL_ACK1;
        end
      end
      CTL_ACK2: begin
        // ACK2 is final only in 8086 mode; 8080 needs a third pulse.
        if (fall_s && !mode_r) begin
          state_nxt_s = CTL_ACK3;
        end else if (rise_s && mode_r) begin
          state_nxt_s = CTL_IDLE;
          eoa_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = CTL_ACK2;
        end
      end
      CTL_ACK3: begin
        if (rise_s) begin
          state_nxt_s = CTL_IDLE;
          eoa_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = CTL_ACK3;
        end
      end
      default: begin
        state_nxt_s = CTL_IDLE;
      end
    endcase

`ifdef INTA_TIMEOUT_EN
    // Count only while waiting (INTA high) for a further pulse.
    timing_s = ((state_r == CTL_ACK1) || ((state_r == CTL_ACK2) && !mode_r)) && !low_s;
    if (fall_s || !timing_s) begin
      cnt_nxt_s = '0;
    end else if (cnt_r == CW'(TIMEOUT_CYCLES - 1)) begin
      cnt_nxt_s   = '0;
      state_nxt_s = CTL_IDLE;
      abort_nxt_s = 1'b1;
      eoa_nxt_s   = 1'b0;
    end else begin
      cnt_nxt_s = cnt_r + CW'(1);
    end
`endif
  end

  // Bus byte for the state being entered, using the values being captured
  // so the first ACK1 cycle already drives correctly.
  always_comb begin
    den_nxt_s  = 1'b0;
    dout_nxt_s = 8'h00;
    if (low_s) begin
      case (state_nxt_s)
        CTL_ACK1: begin
          if (!mode_nxt_s && !cascade_slave) begin
            den_nxt_s  = 1'b1;
            dout_nxt_s = CALL_OPCODE;
          end else begin
            den_nxt_s  = 1'b0;
          end
        end
        CTL_ACK2: begin
          if (cascade_output_ack_2_3) begin
            den_nxt_s = 1'b1;
            if (mode_nxt_s) begin
              dout_nxt_s = {vector_base, ir_nxt_s};
            end else if (call_interval_4) begin
              dout_nxt_s = {call_base[7:5], ir_nxt_s, 2'b00};
            end else begin
              dout_nxt_s = {call_base[7:6], ir_nxt_s, 3'b000};
            end
          end else begin
            den_nxt_s = 1'b0;
          end
        end
        CTL_ACK3: begin
          if (cascade_output_ack_2_3) begin
            den_nxt_s  = 1'b1;
            dout_nxt_s = call_base[15:8];
          end else begin
            den_nxt_s  = 1'b0;
          end
        end
        default: begin
          den_nxt_s = 1'b0;
        end
      endcase
    end else begin
      den_nxt_s = 1'b0;
    end
  end

  // State, captured values and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= CTL_IDLE;
      mode_r     <= 1'b0;
      aeoi_r     <= 1'b0;
      ir_r       <= 3'd0;
      ack_r      <= 8'h00;
      latch_r    <= 1'b0;
      eoa_r      <= 1'b0;
      aeoi_clr_r <= 1'b0;
      abort_r    <= 1'b0;
      dout_r     <= 8'h00;
      den_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      mode_r     <= mode_nxt_s;
      aeoi_r     <= aeoi_nxt_s;
      ir_r       <= ir_nxt_s;
      ack_r      <= ack_nxt_s;
      latch_r    <= latch_nxt_s;
      eoa_r      <= eoa_nxt_s;
      aeoi_clr_r <= eoa_nxt_s & aeoi_r;
      abort_r    <= abort_nxt_s;
      dout_r     <= dout_nxt_s;
      den_r      <= den_nxt_s;
    end
  end

`ifdef INTA_TIMEOUT_EN
  // Inter-pulse timeout counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end
`endif

  assign control_state         = state_r;
  assign acknowledge_interrupt = ack_r;
  assign latch_in_service      = latch_r;
  assign end_of_ack            = eoa_r;
  assign auto_eoi_clear        = aeoi_clr_r;
  assign data_out              = dout_r;
  assign data_out_enable       = den_r;
  assign seq_abort             = abort_r;

endmodule

// File: doc/interrupt_ack_sequencer.md
# interrupt_ack_sequencer

Sequences the 8259A interrupt-acknowledge cycle: it detects INTA pulses, steps the acknowledge state (ACK1/ACK2/ACK3), and captures the acknowledged IR level. It drives the vector or CALL bytes onto the internal data bus and pulses the in-service and auto-EOI strobes. It sits between the INTA pin logic, the priority resolver, and the cascade-signal block. It produces the `control_state` and `acknowledge_interrupt` values that the cascade-signal block consumes, and it gates its own bus drive with that block's `cascade_output_ack_2_3`.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: clocks allowed between INTA pulses before abort; used only with INTA_TIMEOUT_EN.

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- interrupt_ack_n  in  1  INTA pin, already synchronous to clock.
- mode_8086  in  1  ICW4 uPM: 1 = two-pulse 8086 sequence, 0 = three-pulse 8080 CALL sequence.
- auto_eoi  in  1  ICW4 AEOI.
- cascade_slave  in  1  device is a cascade slave.
- cascade_output_ack_2_3  in  1  this device owns the bus for ACK2/ACK3.
- interrupt_to_ack  in  8  priority-resolved request, one-hot or zero.
- vector_base  in  5  ICW2 T7..T3 (8086 mode).
- call_base  in  16  CALL address base (8080 mode).
- call_interval_4  in  1  ICW1 ADI: 1 = interval 4, 0 = interval 8.
- control_state  out  3  IDLE 000, ACK1 001, ACK2 010, ACK3 011.
- acknowledge_interrupt  out  8  captured one-hot acknowledged level.
- latch_in_service  out  1  one-cycle pulse: set ISR bit.
- end_of_ack  out  1  one-cycle pulse at end of last INTA pulse.
- auto_eoi_clear  out  1  one-cycle pulse; equals end_of_ack & captured auto_eoi.
- data_out  out  8  byte driven during an INTA low phase.
- data_out_enable  out  1  data_out valid / bus drive.
- seq_abort  out  1  one-cycle timeout pulse (0 when macro absent).

## Operation
- Edge detect:
  - Register `interrupt_ack_n` into `ack_d`.
  - A fall is `ack_d & ~interrupt_ack_n`; a rise is `~ack_d & interrupt_ack_n`.
- State machine:
  - IDLE→ACK1 on fall.
  - ACK1→ACK2 on fall.
  - ACK2→ACK3 on fall only when captured mode is 8080.
  - The final state (ACK2 for 8086, ACK3 for 8080) →IDLE on rise.
  - All other events hold state. A fall while already in ACK3 is ignored.
- Capture at the IDLE→ACK1 transition:
  - `mode_8086`, `auto_eoi`, and `interrupt_to_ack` are sampled.
  - Later changes to these inputs are ignored until IDLE.
  - `ir` is the index of the lowest set bit of `interrupt_to_ack`.
  - Spurious case (`interrupt_to_ack` == 0): `ir` = 7, `acknowledge_interrupt` = 0, and no `latch_in_service` pulse.
- `latch_in_service` pulses with the IDLE→ACK1 transition when a request is present.
- `end_of_ack` pulses with the final →IDLE transition.
- Bus drive: `data_out_enable` is high only while INTA is low inside the ACK states.
  - ACK1, 8080 mode, `cascade_slave` = 0: drive 8'hCD. ACK1 in 8086 mode: no drive.
  - ACK2, 8086 mode: drive {vector_base, ir}.
  - ACK2, 8080 mode, interval 4: drive {call_base[7:5], ir, 2'b00}.
  - ACK2, 8080 mode, interval 8: drive {call_base[7:6], ir, 3'b000}.
  - ACK3, 8080 mode: drive call_base[15:8].
  - ACK2 and ACK3 drive only when `cascade_output_ack_2_3` = 1.
- `data_out` = 0 whenever `data_out_enable` = 0.

## Timing
- Reset: all outputs are 0, `control_state` = IDLE, and `ack_d` = 1. Reset is asynchronous and may arrive mid-sequence; the sequence is then discarded with no `end_of_ack`.
- Pin-to-state latency: 2 clocks from the pin's falling edge to `control_state` and `data_out_enable` updating. All outputs are registered.
- Rise latency: `data_out_enable` drops, and the final state returns to IDLE, 2 clocks after the pin rises.
- Pulses (`latch_in_service`, `end_of_ack`, `auto_eoi_clear`, `seq_abort`) are exactly one clock wide.
- A fall and a rise cannot coincide. A one-clock-low glitch still counts as a full pulse.

## Configuration
- INTA_TIMEOUT_EN defined:
  - A counter runs in ACK1 and ACK2 (8080 mode) while INTA is high.
  - When it reaches TIMEOUT_CYCLES, the block returns to IDLE, pulses `seq_abort`, and does not pulse `end_of_ack`.
  - The counter clears on every fall.
- INTA_TIMEOUT_EN undefined: the block waits indefinitely, and `seq_abort` is tied to 0.

## Structure
- Package `pic8259_pkg` holds:
  - the `control_state` encodings CTL_IDLE/CTL_ACK1/CTL_ACK2/CTL_ACK3;
  - the CALL opcode constant 8'hCD;
  - the `ir` encoder function.
- One sub-module, `inta_edge_detect`, holds the `ack_d` register and produces the fall/rise/low strobes.

## Test plan
- 8086, `vector_base`=5'h10, `interrupt_to_ack`=8'h08, two INTA pulses:
  - `latch_in_service` pulses once; `acknowledge_interrupt`=8'h08.
  - ACK2 `data_out`=8'h83.
  - `end_of_ack` fires on the second rise; state returns to IDLE.
- 8080, `call_base`=16'h12E0, interval 4, IR5, three pulses:
  - `data_out` sequence CD, F4, 12; IDLE after the third rise.
- Spurious: `interrupt_to_ack`=0, 8086, `vector_base`=5'h08:
  - ACK2 `data_out`=8'h47; no `latch_in_service`; `acknowledge_interrupt`=0.
- Slave with `cascade_output_ack_2_3`=0:
  - `data_out_enable` stays 0 through the whole sequence; states still advance.
- `auto_eoi`=1, 8086:
  - `auto_eoi_clear` coincides with `end_of_ack`.
  - Drop `auto_eoi` after ACK1: `auto_eoi_clear` still pulses (captured value).
- `reset_n` low during ACK2: all outputs 0 immediately, IDLE.
  - With INTA_TIMEOUT_EN and TIMEOUT_CYCLES=10, a stall in ACK1 gives `seq_abort` at count 10.
